// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - 4-digit multiplexed 7-segment clock display scanner
// Frame-snapshotted inputs, per-slot blanking cycle, blinking colon in time mode.
module clock_display_scan #(
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] HOURS_IN,
   input  logic [5:0] MINUTES_IN,
   input  logic       AM_PM_IN,
   input  logic       ALARM_MODE,
   output logic [3:0] DIGIT_SEL,
   output logic [6:0] SEG,
   output logic       COLON,
   output logic       PM_LED,
   output logic       ALARM_LED
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   localparam logic [3:0] CODE_DASH  = 4'd10;
   localparam logic [3:0] CODE_BLANK = 4'd11;
   localparam logic [6:0] SEG_BLANK  = 7'b1111111;

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [BW-1:0] blink_cnt;
   logic          phase;
   logic [3:0]    snap_h;
   logic [5:0]    snap_m;
   logic          snap_pm;
   logic          snap_alarm;

   logic [3:0] hr_tens, hr_ones, mn_tens, mn_ones, cur_code;
   logic [6:0] cur_glyph;
   logic       frame_end;

   function automatic logic [6:0] glyph(input logic [3:0] code);
      case (code)
         4'd0:    glyph = 7'b1000000;
         4'd1:    glyph = 7'b1111001;
         4'd2:    glyph = 7'b0100100;
         4'd3:    glyph = 7'b0110000;
         4'd4:    glyph = 7'b0011001;
         4'd5:    glyph = 7'b0010010;
         4'd6:    glyph = 7'b0000010;
         4'd7:    glyph = 7'b1111000;
         4'd8:    glyph = 7'b0000000;
         4'd9:    glyph = 7'b0010000;
         4'd10:   glyph = 7'b0111111;
         default: glyph = SEG_BLANK;
      endcase
   endfunction

   // Hour 0 reads as 12; 1..9 suppress the leading zero; 13..15 are invalid.
   always_comb begin
      hr_tens = CODE_DASH;
      hr_ones = CODE_DASH;
      if (snap_h == 4'd0) begin
         hr_tens = 4'd1;
         hr_ones = 4'd2;
      end else if (snap_h <= 4'd9) begin
         hr_tens = CODE_BLANK;
         hr_ones = snap_h;
      end else if (snap_h <= 4'd12) begin
         hr_tens = 4'd1;
         hr_ones = snap_h - 4'd10;
      end
      mn_tens = CODE_DASH;
      mn_ones = CODE_DASH;
      if (snap_m <= 6'd59) begin
         mn_tens = 4'(snap_m / 6'd10);
         mn_ones = 4'(snap_m % 6'd10);
      end
      case (idx)
         2'd0:    cur_code = hr_tens;
         2'd1:    cur_code = hr_ones;
         2'd2:    cur_code = mn_tens;
         default: cur_code = mn_ones;
      endcase
      cur_glyph = glyph(cur_code);
      frame_end = (idx == 2'd3) && (cnt == CNT_LAST);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt        <= '0;
         idx        <= 2'd0;
         blink_cnt  <= '0;
         phase      <= 1'b1;
         snap_h     <= 4'd0;
         snap_m     <= 6'd0;
         snap_pm    <= 1'b0;
         snap_alarm <= 1'b0;
         DIGIT_SEL  <= 4'b1111;
         SEG        <= SEG_BLANK;
         COLON      <= 1'b0;
         PM_LED     <= 1'b0;
         ALARM_LED  <= 1'b0;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (frame_end) begin
            snap_h     <= HOURS_IN;
            snap_m     <= MINUTES_IN;
            snap_pm    <= AM_PM_IN;
            snap_alarm <= ALARM_MODE;
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt <= '0;
               phase     <= ~phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
         // First cycle of every slot is dark so the previous digit cannot ghost.
         if (cnt == '0) begin
            DIGIT_SEL <= 4'b1111;
            SEG       <= SEG_BLANK;
         end else begin
            DIGIT_SEL <= ~(4'b0001 << idx);
            SEG       <= cur_glyph;
         end
         COLON     <= snap_alarm | phase;
         PM_LED    <= snap_pm;
         ALARM_LED <= snap_alarm;
      end
   end

endmodule

// File: tb/tb_clock_display_scan.sv
// tb/tb_clock_display_scan.sv - scoreboard bench for clock_display_scan
// SCAN_DIV=4, BLINK_FRAMES=2: one frame is 16 output cycles.
module tb_clock_display_scan;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] hours;
   logic [5:0] minutes;
   logic       am_pm;
   logic       alarm_mode;
   logic [3:0] digit_sel;
   logic [6:0] seg;
   logic       colon, pm_led, alarm_led;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [13:0] exp_q[$];

   // model of the snapshot shown in the frame about to be scanned
   logic [3:0] sh;
   logic [5:0] sm;
   logic       spm, sal;
   int         frm;

   localparam logic [13:0] RESET_VEC = {4'b1111, 7'b1111111, 1'b0, 1'b0, 1'b0};

   clock_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
      .CLK(clk), .RESET(rst), .HOURS_IN(hours), .MINUTES_IN(minutes),
      .AM_PM_IN(am_pm), .ALARM_MODE(alarm_mode), .DIGIT_SEL(digit_sel),
      .SEG(seg), .COLON(colon), .PM_LED(pm_led), .ALARM_LED(alarm_led)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input int code);
      case (code)
         0:  seg_of = 7'b1000000;
         1:  seg_of = 7'b1111001;
         2:  seg_of = 7'b0100100;
         3:  seg_of = 7'b0110000;
         4:  seg_of = 7'b0011001;
         5:  seg_of = 7'b0010010;
         6:  seg_of = 7'b0000010;
         7:  seg_of = 7'b1111000;
         8:  seg_of = 7'b0000000;
         9:  seg_of = 7'b0010000;
         10: seg_of = 7'b0111111;
         default: seg_of = 7'b1111111;
      endcase
   endfunction

   task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic push_frame();
      int c[4];
      logic [3:0] sel_tab[4];
      logic col;
      int h, m;
      sel_tab[0] = 4'b1110; sel_tab[1] = 4'b1101;
      sel_tab[2] = 4'b1011; sel_tab[3] = 4'b0111;
      h = int'(sh);
      m = int'(sm);
      if (h == 0)       begin c[0] = 1;  c[1] = 2;      end
      else if (h < 10)  begin c[0] = 11; c[1] = h;      end
      else if (h < 13)  begin c[0] = 1;  c[1] = h - 10; end
      else              begin c[0] = 10; c[1] = 10;     end
      if (m < 60)       begin c[2] = m / 10; c[3] = m % 10; end
      else              begin c[2] = 10; c[3] = 10;     end
      col = sal ? 1'b1 : ((frm / 2) % 2 == 0);
      for (int d = 0; d < 4; d++) begin
         exp_q.push_back({4'b1111, 7'b1111111, col, spm, sal});
         repeat (3) exp_q.push_back({sel_tab[d], seg_of(c[d]), col, spm, sal});
      end
   endtask

   // Scan one frame; optionally change inputs while idx=1 is on screen.
   task automatic run_frame(input string tag, input bit chg, input logic [3:0] nh,
                            input logic [5:0] nm, input bit npm, input bit nal);
      logic [13:0] exp;
      push_frame();
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #1;
         if (chg && i == 5) begin
            hours = nh; minutes = nm; am_pm = npm; alarm_mode = nal;
         end
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s scoreboard empty at cycle %0d", tag, i);
         end else begin
            exp = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, i),
                  {digit_sel, seg, colon, pm_led, alarm_led}, exp);
         end
      end
      sh = hours; sm = minutes; spm = am_pm; sal = alarm_mode;
      frm++;
   endtask

   task automatic model_reset();
      sh = 4'd0; sm = 6'd0; spm = 1'b0; sal = 1'b0; frm = 0;
      exp_q.delete();
   endtask

   initial begin
      hours = 4'd3; minutes = 6'd7; am_pm = 1'b1; alarm_mode = 1'b0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {digit_sel, seg, colon, pm_led, alarm_led}, RESET_VEC);
      @(negedge clk);
      rst = 1'b0;

      run_frame("f0_1200_am", 1'b0, 4'd0, 6'd0, 1'b0, 1'b0);
      hours = 4'd0; minutes = 6'd59; am_pm = 1'b0;
      run_frame("f1_307_pm", 1'b0, 4'd0, 6'd0, 1'b0, 1'b0);
      hours = 4'd14; minutes = 6'd62;
      run_frame("f2_1259", 1'b0, 4'd0, 6'd0, 1'b0, 1'b0);
      hours = 4'd10; minutes = 6'd30;
      run_frame("f3_dashes", 1'b0, 4'd0, 6'd0, 1'b0, 1'b0);
      run_frame("f4_1030_midchg", 1'b1, 4'd11, 6'd45, 1'b0, 1'b0);
      run_frame("f5_1145", 1'b0, 4'd0, 6'd0, 1'b0, 1'b0);
      run_frame("f6_blink", 1'b0, 4'd0, 6'd0, 1'b0, 1'b0);
      alarm_mode = 1'b1;
      run_frame("f7_blink", 1'b0, 4'd0, 6'd0, 1'b0, 1'b0);
      run_frame("f8_alarm", 1'b0, 4'd0, 6'd0, 1'b0, 1'b0);
      run_frame("f9_alarm", 1'b0, 4'd0, 6'd0, 1'b0, 1'b0);

      repeat (6) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_midslot", {digit_sel, seg, colon, pm_led, alarm_led}, RESET_VEC);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      run_frame("r0_after_reset", 1'b0, 4'd0, 6'd0, 1'b0, 1'b0);
      run_frame("r1_alarm", 1'b0, 4'd0, 6'd0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
